reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
Debug/trace block that reads the processor register file sequentially through one spare read port and streams every register out as (address, data) words over a valid/ready handshake.
It sits beside the register file, driving that file's read address and consuming its combinational read data.
The downstream consumer (UART bridge, trace FIFO, testbench monitor) receives one register per beat.
It lets software, the debugger or the verification bench snapshot architectural state without stalling the core's write path.

Parameters:
NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1)
ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS
DATA_W, 32, register data width
SKIP_ZERO, 0, when 1 the dump starts at address 1 (x0 omitted)

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a dump; sampled in IDLE only
abort  input  1  synchronous cancel of a dump in progress
rg_rd_addr  output  ADDR_W  read address to register file read port
rg_rd_data  input  DATA_W  combinational read data from register file
dump_valid  output  1  output word valid
dump_ready  input  1  consumer accepts word when high with dump_valid
dump_addr  output  ADDR_W  register index of current word
dump_data  output  DATA_W  register contents of current word
dump_last  output  1  high with dump_valid on final word
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after last word accepted

Behaviour:
- Reset is Reset, asynchronous, active-high; clock is CLK. Reset forces state=IDLE, idx=0, rg_rd_addr=0, dump_valid=0, dump_addr=0, dump_data=0, dump_last=0, busy=0, done=0. Reset mid-dump discards it; no further words are emitted.
- All outputs are registered. FIRST = SKIP_ZERO ? 1 : 0. LAST = NUM_REGS-1.
- States:
  - IDLE: start=1 at an edge -> idx<=FIRST, rg_rd_addr<=FIRST, go READ.
  - READ: at next edge, dump_data<=rg_rd_data, dump_addr<=idx, dump_last<=(idx==LAST), dump_valid<=1, go SEND.
  - SEND: dump_valid, dump_addr, dump_data and dump_last are held stable until dump_valid&dump_ready at an edge. On that handshake, dump_valid<=0. If idx==LAST, go DONE. Otherwise idx<=idx+1, rg_rd_addr<=idx+1, go READ.
  - DONE: done=1 for exactly this one cycle, then go IDLE.
- In IDLE and DONE, rg_rd_addr=0.
- Throughput: one word per 2 cycles at most. Word k (counting from 0) becomes valid after edge 2k+1 relative to the start edge E0, given no backpressure.
- Data capture: a word is snapshotted at the READ->SEND edge. A register-file write to the same address at that same edge is not reflected (pre-write value captured). Later writes do not alter a word already held in SEND.
- start while busy=1: ignored, never queued.
- abort in READ or SEND: at the next edge go IDLE with dump_valid=0 and dump_last=0; done is not pulsed. This is the only case where valid drops without a handshake.
- abort in IDLE or DONE: no effect; DONE still returns to IDLE and done still pulses.
- abort and start together in IDLE: start wins.
- idx never exceeds LAST, so no wrap-around occurs.
- dump_ready is ignored when dump_valid=0.

Test Plan:
- Full dump, SKIP_ZERO=0, regfile preloaded with reg[i]=0x1000+i, dump_ready=1, start pulse at E0 -> 32 beats with addr 0..31 and data 0x1000..0x101F. dump_last only on addr 31. Word k valid after E(2k+1). done pulses after E64. busy=0 after E65.
- Backpressure: dump_ready low for 5 cycles on beat 3 -> dump_valid/addr=3/data=0x1003 held stable all 5 cycles. Next beat is addr 4. Total beat count is still 32.
- SKIP_ZERO=1 -> 31 beats, first dump_addr=1, last beat addr 31 with dump_last=1, x0 never emitted.
- Concurrent write: regfile writes reg[5]=0xDEADBEEF at the same edge that captures word 5 (old value 0x1005) -> dump_data=0x1005. A second dump then returns 0xDEADBEEF for addr 5.
- abort during SEND of addr 10 -> dump_valid=0 next cycle, state IDLE, no done pulse. A new start then dumps from addr 0.
- Reset asserted mid-dump (addr 7), plus start re-pulsed while busy -> all outputs zero immediately on Reset. The re-pulsed start while busy produces no second dump.

Source files
------------

// File: rtl/reg_dump_reader_if.sv
// Register-dump stream: one (address, data) word per valid/ready beat.
interface reg_dump_reader_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        output dump_valid,
        output dump_addr,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_addr,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file through a spare read port and streams each register
// out as an (address, data) word; one word every two cycles at best.
module reg_dump_reader #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rg_rd_addr,
    input  logic [DATA_W-1:0] rg_rd_data,
    reg_dump_reader_if.master dump,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] FIRST = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] idx_q,     idx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              valid_q,   valid_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              last_q,    last_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        last_d    = last_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d     = FIRST;
                    rd_addr_d = FIRST;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (abort) begin
                    rd_addr_d = '0;
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    // Snapshot taken here; a same-edge write lands after capture.
                    data_d  = rg_rd_data;
                    addr_d  = idx_q;
                    last_d  = (idx_q == LAST);
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    rd_addr_d = '0;
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (valid_q && dump.dump_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == LAST) begin
                        rd_addr_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        rd_addr_d = idx_q + 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                rd_addr_d = '0;
                valid_d   = 1'b0;
                last_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rg_rd_addr      = rd_addr_q;
    assign dump.dump_valid = valid_q;
    assign dump.dump_addr  = addr_q;
    assign dump.dump_data  = data_q;
    assign dump.dump_last  = last_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: full dumps, backpressure, abort,
// mid-dump reset and a SKIP_ZERO instance.
module tb_reg_dump_reader;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          CLK     = 1'b0;
    logic          Reset   = 1'b1;
    logic          start_a = 1'b0;
    logic          abort_a = 1'b0;
    logic          ready_a = 1'b1;
    logic          start_b = 1'b0;
    logic          ready_b = 1'b1;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          busy_a, done_a, busy_b, done_b;

    logic [DW-1:0] rf [NR];
    logic          rf_init = 1'b1;
    logic          we      = 1'b0;
    logic [AW-1:0] wa      = '0;
    logic [DW-1:0] wd      = '0;

    word_t qa[$];
    word_t qb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats_a  = 0;
    int    beats_b  = 0;
    int    stall_a  = 0;
    int    bp_left  = 0;

    reg_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    reg_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0)) dut_a (
        .CLK(CLK), .Reset(Reset), .start(start_a), .abort(abort_a),
        .rg_rd_addr(rd_addr_a), .rg_rd_data(rd_data_a), .dump(ifa),
        .busy(busy_a), .done(done_a)
    );

    reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1)) dut_b (
        .CLK(CLK), .Reset(Reset), .start(start_b), .abort(1'b0),
        .rg_rd_addr(rd_addr_b), .rg_rd_data(rd_data_b), .dump(ifb),
        .busy(busy_b), .done(done_b)
    );

    assign ifa.dump_ready = ready_a;
    assign ifb.dump_ready = ready_b;
    assign rd_data_a      = rf[rd_addr_a];
    assign rd_data_b      = rf[rd_addr_b];

    always #5 CLK = ~CLK;

    // Register file model: written at the clock edge, read combinationally.
    always @(posedge CLK) begin
        if (rf_init) begin
            for (int i = 0; i < NR; i++) rf[i] <= 32'h1000 + i;
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Backpressure: hold ready low for bp_left cycles once addr 3 is offered.
    always @(posedge CLK) begin
        #1;
        if (bp_left > 0 && ifa.dump_valid && ifa.dump_addr == AW'(3)) begin
            ready_a = 1'b0;
            bp_left--;
        end else begin
            ready_a = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (!Reset && ifa.dump_valid) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_beat: got addr %0d, expected no word", ifa.dump_addr);
            end else begin
                check("a_word", {ifa.dump_addr, ifa.dump_data, ifa.dump_last}, qa[0]);
                if (ifa.dump_ready && !abort_a) begin
                    void'(qa.pop_front());
                    beats_a++;
                end else if (!ifa.dump_ready) begin
                    stall_a++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!Reset && ifb.dump_valid) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_beat: got addr %0d, expected no word", ifb.dump_addr);
            end else begin
                check("b_word", {ifb.dump_addr, ifb.dump_data, ifb.dump_last}, qb[0]);
                if (ifb.dump_ready) begin
                    void'(qb.pop_front());
                    beats_b++;
                end
            end
        end
    end

    task automatic push_a(input logic [DW-1:0] r5);
        for (int i = 0; i < NR; i++) begin
            word_t w;
            w.addr = AW'(i);
            w.data = (i == 5) ? r5 : 32'h1000 + i;
            w.last = (i == NR - 1);
            qa.push_back(w);
        end
    endtask

    task automatic run_a(input int exp_cycles, input int exp_stall, input int wr_at, input bit busy_start);
        int n = 0;
        beats_a = 0;
        stall_a = 0;
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a = 1'b0;
        check("a_busy_after_start", busy_a, 1);
        while (!done_a && n < 400) begin
            we      = (n == wr_at - 1);
            wa      = AW'(5);
            wd      = 32'hDEAD_BEEF;
            start_a = busy_start && (n == 20);
            @(posedge CLK); #1;
            n++;
        end
        we      = 1'b0;
        start_a = 1'b0;
        check("a_done_cycle", n, exp_cycles);
        check("a_beats", beats_a, NR);
        check("a_stall_cycles", stall_a, exp_stall);
        check("a_queue_empty", qa.size(), 0);
        @(posedge CLK); #1;
        check("a_done_one_cycle", done_a, 0);
        check("a_idle_busy", busy_a, 0);
    endtask

    task automatic wait_addr_a(input logic [AW-1:0] target, input int exp_n);
        int n = 0;
        while (!(ifa.dump_valid && ifa.dump_addr == target) && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("a_word_arrival", n, exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("a_reset_outputs", {ifa.dump_valid, ifa.dump_addr, ifa.dump_data, ifa.dump_last,
                                  busy_a, done_a, rd_addr_a}, 0);
        check("b_reset_outputs", {ifb.dump_valid, ifb.dump_addr, ifb.dump_data, ifb.dump_last,
                                  busy_b, done_b, rd_addr_b}, 0);
        Reset   = 1'b0;
        rf_init = 1'b0;
        @(posedge CLK); #1;

        // Full dump; reg 5 rewritten on the edge that captures word 5 (E11).
        push_a(32'h0000_1005);
        run_a(64, 0, 11, 1'b0);

        // Five-cycle stall on addr 3; the new reg 5 value is now visible.
        push_a(32'hDEAD_BEEF);
        bp_left = 5;
        run_a(69, 5, -1, 1'b0);

        // Abort while addr 10 is offered.
        push_a(32'hDEAD_BEEF);
        beats_a = 0;
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a = 1'b0;
        wait_addr_a(AW'(10), 21);
        abort_a = 1'b1;
        @(posedge CLK); #1;
        abort_a = 1'b0;
        check("a_abort_state", {ifa.dump_valid, ifa.dump_last, busy_a, rd_addr_a}, 0);
        check("a_abort_beats", beats_a, 10);
        check("a_abort_left", qa.size(), 22);
        qa.delete();
        for (int i = 0; i < 5; i++) begin
            check("a_abort_no_done", done_a, 0);
            @(posedge CLK); #1;
        end

        // Fresh dump from addr 0 with a start re-pulsed mid-dump.
        push_a(32'hDEAD_BEEF);
        run_a(64, 0, -1, 1'b1);
        repeat (10) begin
            @(posedge CLK); #1;
        end
        check("a_no_second_dump", busy_a, 0);

        // Reset asserted mid-dump, start re-pulsed while busy just before it.
        push_a(32'hDEAD_BEEF);
        beats_a = 0;
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a = 1'b0;
        wait_addr_a(AW'(7), 15);
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("a_midreset_outputs", {ifa.dump_valid, ifa.dump_addr, ifa.dump_data, ifa.dump_last,
                                     busy_a, done_a, rd_addr_a}, 0);
        check("a_beats_before_reset", beats_a, 8);
        qa.delete();
        @(posedge CLK); #1;
        Reset = 1'b0;
        repeat (20) begin
            @(posedge CLK); #1;
        end
        check("a_after_reset_idle", busy_a, 0);

        // SKIP_ZERO instance: 31 words from addr 1.
        for (int i = 1; i < NR; i++) begin
            word_t w;
            w.addr = AW'(i);
            w.data = (i == 5) ? 32'hDEAD_BEEF : 32'h1000 + i;
            w.last = (i == NR - 1);
            qb.push_back(w);
        end
        begin
            int n = 0;
            beats_b = 0;
            start_b = 1'b1;
            @(posedge CLK); #1;
            start_b = 1'b0;
            while (!done_b && n < 400) begin
                @(posedge CLK); #1;
                n++;
            end
            check("b_done_cycle", n, 62);
            check("b_beats", beats_b, NR - 1);
            check("b_queue_empty", qb.size(), 0);
            @(posedge CLK); #1;
            check("b_idle_busy", {busy_b, done_b}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
